// File: rtl/proc_pkg.sv
// proc_pkg: shared types, opcodes and instruction field positions for the processor control path
package proc_pkg;
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
  typedef enum logic [3:0] {
    BUS_NONE = 4'd0, BUS_R0 = 4'd1, BUS_R1 = 4'd2, BUS_R2 = 4'd3, BUS_R3 = 4'd4,
    BUS_R4 = 4'd5, BUS_R5 = 4'd6, BUS_R6 = 4'd7, BUS_R7 = 4'd8,
    BUS_G = 4'd9, BUS_DIN = 4'd10
  } bus_sel_t;
  localparam logic [3:0] OP_MV = 4'h0;
  localparam logic [3:0] OP_MVI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RX_HI = 11;
  localparam int RX_LO = 9;
  localparam int RY_HI = 8;
  localparam int RY_LO = 6;
  localparam int REG_W = 3;
  function automatic bus_sel_t bus_reg(input logic [REG_W-1:0] r);
    return bus_sel_t'(4'(BUS_R0) + 4'(r));
  endfunction
endpackage

// File: rtl/reg_decoder.sv
// reg_decoder: register index to one-hot load enable, all zero when disabled
module reg_decoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);
  assign onehot = en ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: T0..T3 sequencer decoding IR into register enables, bus select and ALU control
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int N_REGS = 8,
  parameter int IR_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [IR_WIDTH-1:0] ir,
  output logic                ir_in,
  output logic [N_REGS-1:0]   r_in,
  output logic                a_in,
  output logic                g_in,
  output logic                add_sub,
  output bus_sel_t            bus_sel,
  output logic                done
);
  state_t state_q, state_d;
  logic [3:0] op;
  logic [REG_W-1:0] rx, ry;
  logic is_alu, r_en;
  logic unused_ir_bits;
  assign op = ir[OP_HI:OP_LO];
  assign rx = ir[RX_HI:RX_LO];
  assign ry = ir[RY_HI:RY_LO];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
  assign unused_ir_bits = ^ir[RY_LO-1:0];
  always_ff @(posedge clk)
    state_q <= rst ? state_d : T0;
  always_comb
    state_d = (state_q == T0) ? (run ? T1 : T0) :
              (state_q == T1) ? (is_alu ? T2 : T0) :
              (state_q == T2) ? T3 : T0;
  // Everything is gated by rst so a mid-instruction reset kills the pending write in that same cycle.
  always_comb begin
    ir_in = 1'b0;
    r_en = 1'b0;
    a_in = 1'b0;
    g_in = 1'b0;
    add_sub = 1'b0;
    bus_sel = BUS_NONE;
    done = 1'b0;
    if (rst) begin
      case (state_q)
        T0: ir_in = run;
        T1: begin
          bus_sel = (op == OP_MV) ? bus_reg(ry) : (op == OP_MVI) ? BUS_DIN : is_alu ? bus_reg(rx) : BUS_NONE;
          r_en = (op == OP_MV) || (op == OP_MVI);
          a_in = is_alu;
          done = !is_alu;
        end
        T2: begin
          bus_sel = bus_reg(ry);
          g_in = 1'b1;
          add_sub = (op == OP_SUB);
        end
        T3: begin
          bus_sel = BUS_G;
          r_en = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end
  reg_decoder #(.N(N_REGS), .W(REG_W)) u_dec (.en(r_en), .idx(rx), .onehot(r_in));
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: scenario tasks with a per-cycle expected-output scoreboard
module tb_proc_control_fsm;
  typedef struct packed {
    logic ir_in;
    logic [7:0] r_in;
    logic a_in;
    logic g_in;
    logic add_sub;
    logic [3:0] bus;
    logic done;
  } exp_t;
  typedef struct packed {
    logic rst;
    logic run;
    logic [15:0] ir;
    exp_t e;
  } stim_t;
  logic clk = 1'b0;
  logic rst, run;
  logic [15:0] ir;
  logic ir_in, a_in, g_in, add_sub, done;
  logic [7:0] r_in;
  logic [3:0] bus_sel;
  exp_t exp_q[$];
  int passed = 0;
  int total = 0;
  proc_control_fsm #(.N_REGS(8), .IR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .run(run), .ir(ir), .ir_in(ir_in), .r_in(r_in),
    .a_in(a_in), .g_in(g_in), .add_sub(add_sub), .bus_sel(bus_sel), .done(done)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic i, input logic [7:0] r, input logic a, input logic g,
                              input logic s, input logic [3:0] b, input logic d);
    return '{i, r, a, g, s, b, d};
  endfunction
  function automatic exp_t sample();
    return '{ir_in, r_in, a_in, g_in, add_sub, bus_sel, done};
  endfunction
  task automatic cyc(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst;
    run = s.run;
    ir = s.ir;
    exp_q.push_back(s.e);
    @(negedge clk);
  endtask
  localparam exp_t Z = '0;
  task automatic test_reset();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b0, 1'b1, 16'h1600, Z});
    seq.push_back('{1'b0, 1'b1, 16'h1600, Z});
    seq.push_back('{1'b1, 1'b1, 16'h0000, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h0000, mk(0, 8'h01, 0, 0, 0, 4'd1, 1)});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL reset cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_mvi();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b1, 1'b1, 16'h1600, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h1600, mk(0, 8'h08, 0, 0, 0, 4'd10, 1)});
    seq.push_back('{1'b1, 1'b0, 16'h1600, Z});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL mvi cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_mv();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b1, 1'b1, 16'h0A80, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h0A80, mk(0, 8'h20, 0, 0, 0, 4'd3, 1)});
    seq.push_back('{1'b1, 1'b0, 16'h0A80, Z});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL mv cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_nop();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b1, 1'b1, 16'hF000, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'hF000, mk(0, 8'h00, 0, 0, 0, 4'd0, 1)});
    seq.push_back('{1'b1, 1'b0, 16'hF000, Z});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL nop cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_add();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b1, 1'b1, 16'h2300, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h2300, mk(0, 8'h00, 1, 0, 0, 4'd2, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h2300, mk(0, 8'h00, 0, 1, 0, 4'd5, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h2300, mk(0, 8'h02, 0, 0, 0, 4'd9, 1)});
    seq.push_back('{1'b1, 1'b0, 16'h2300, Z});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL add cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_sub();
    stim_t seq[$];
    exp_t got, e;
    int dones = 0;
    seq.push_back('{1'b1, 1'b1, 16'h3FC0, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h3FC0, mk(0, 8'h00, 1, 0, 0, 4'd8, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h3FC0, mk(0, 8'h00, 0, 1, 1, 4'd8, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h3FC0, mk(0, 8'h80, 0, 0, 0, 4'd9, 1)});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      dones += int'(done);
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL sub cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
    total++;
    if (dones !== 1) $display("FAIL sub_done_count: got %0d expected 1", dones);
    else passed++;
  endtask
  task automatic test_back_to_back();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b1, 1'b1, 16'h1600, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b1, 16'h1600, mk(0, 8'h08, 0, 0, 0, 4'd10, 1)});
    seq.push_back('{1'b1, 1'b1, 16'h2300, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b1, 16'h2300, mk(0, 8'h00, 1, 0, 0, 4'd2, 0)});
    seq.push_back('{1'b1, 1'b1, 16'h2300, mk(0, 8'h00, 0, 1, 0, 4'd5, 0)});
    seq.push_back('{1'b1, 1'b1, 16'h2300, mk(0, 8'h02, 0, 0, 0, 4'd9, 1)});
    seq.push_back('{1'b1, 1'b0, 16'h2300, Z});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL back_to_back cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_reset_mid();
    stim_t seq[$];
    exp_t got, e;
    seq.push_back('{1'b1, 1'b1, 16'h2300, mk(1, 8'h00, 0, 0, 0, 4'd0, 0)});
    seq.push_back('{1'b1, 1'b0, 16'h2300, mk(0, 8'h00, 1, 0, 0, 4'd2, 0)});
    seq.push_back('{1'b0, 1'b0, 16'h2300, Z});
    seq.push_back('{1'b1, 1'b0, 16'h2300, Z});
    seq.push_back('{1'b1, 1'b0, 16'h2300, Z});
    foreach (seq[i]) begin
      cyc(seq[i]);
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL reset_mid cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  task automatic test_idle();
    exp_t got, e;
    for (int i = 0; i < 5; i++) begin
      cyc('{1'b1, 1'b0, 16'h2300, Z});
      got = sample();
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL idle cycle %0d: got %h expected %h", i, got, e);
      else passed++;
    end
  endtask
  initial begin
    rst = 1'b0;
    run = 1'b0;
    ir = '0;
    test_reset();
    test_mvi();
    test_mv();
    test_nop();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
